jzjpcc_mem_arbiter: RTL and testbench
=====================================

JZJPCC_MEM_ARBITER -- requirements
Module: jzjpcc_mem_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter RAM_A_WIDTH SHALL default to 12 and give the RAM word-address width.
REQ-003 Parameter PC_MAX_B SHALL default to RAM_A_WIDTH + 1 and give the MSB of word addresses [PC_MAX_B:2].
REQ-004 Parameter STARVE_MAX SHALL default to 4, legal range 1..15, and give the fetch starvation limit in cycles.
REQ-005 Port list (name direction width meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low
- fetchReq  in  1  fetch requests a word read this cycle
- fetchAddr  in  [PC_MAX_B:2]  fetch word address
- stallFetch  out  1  fetch request not granted this cycle
- fetchValid  out  1  fetchData valid
- fetchData  out  32  fetched word
- dataReq  in  1  memory stage requests access
- dataWrite  in  1  1 = write, 0 = read
- dataByteEnable  in  4  write byte lanes
- dataAddr  in  [PC_MAX_B:2]  data word address
- dataWriteData  in  32  store data
- stallMemory  out  1  data request not granted this cycle
- dataValid  out  1  dataReadData valid
- dataReadData  out  32  loaded word
- ramAddr  out  RAM_A_WIDTH  single-port RAM word address
- ramWriteEnable  out  1  RAM write strobe
- ramByteEnable  out  4  RAM byte lanes
- ramWriteData  out  32  RAM write data
- ramReadData  in  32  RAM read data, registered, 1-cycle latency

Function
REQ-006 The block SHALL grant the RAM to at most one requester per cycle; grant is combinational from the current requests and registered state.
REQ-007 Priority SHALL be data over fetch, unless starveCount == STARVE_MAX and fetchReq = 1, in which case fetch wins that cycle.
REQ-008 starveCount (4 bits) SHALL increment each cycle fetchReq = 1 and fetch is not granted, saturating at STARVE_MAX, and SHALL clear when fetch is granted or fetchReq = 0.
REQ-009 stallFetch SHALL equal fetchReq AND NOT fetch granted; stallMemory SHALL equal dataReq AND NOT data granted; both combinational.
REQ-010 When fetch is granted: ramAddr = fetchAddr[RAM_A_WIDTH+1:2], ramWriteEnable = 0.
REQ-011 When data is granted: ramAddr = dataAddr[RAM_A_WIDTH+1:2], ramWriteEnable = dataWrite, ramByteEnable = dataByteEnable, ramWriteData = dataWriteData.
REQ-012 When nothing is granted: ramWriteEnable = 0, ramByteEnable = 0, ramAddr = 0, ramWriteData = 0.
REQ-013 A registered owner state SHALL take values NONE, FETCH or DATA_READ; next owner = FETCH on fetch grant, DATA_READ on data read grant, otherwise NONE (includes data writes).
REQ-014 fetchValid SHALL be 1 exactly when owner = FETCH, with fetchData = ramReadData; otherwise fetchData = 0.
REQ-015 dataValid SHALL be 1 exactly when owner = DATA_READ, with dataReadData = ramReadData; otherwise dataReadData = 0.
REQ-016 Read latency SHALL be one cycle from grant to valid; writes complete in the grant cycle and produce no valid pulse.
REQ-017 Back-to-back grants SHALL be allowed every cycle; a grant in cycle N does not block any grant in cycle N+1.
REQ-018 Simultaneous fetchReq and dataReq with starveCount < STARVE_MAX SHALL grant data and stall fetch.
REQ-019 Address bits above RAM_A_WIDTH+1 SHALL be ignored; addresses wrap modulo 2^RAM_A_WIDTH words.

Reset
REQ-020 On a rising clock edge with reset = 0, owner SHALL become NONE and starveCount 0.
REQ-021 During and after reset, fetchValid = 0, dataValid = 0, fetchData = 0 and dataReadData = 0 until a new grant completes.
REQ-022 A read granted in the cycle reset is asserted SHALL be discarded, with no valid pulse after reset release.
REQ-023 ramWriteEnable SHALL be 0 while reset = 0, regardless of requests.

Verification
REQ-024 Fetch only, fetchReq = 1, fetchAddr = 0x10 -> ramAddr = 0x10, stallFetch = 0; next cycle fetchValid = 1 and fetchData = RAM[0x10].
REQ-025 Both requesting, data read at 0x20 with fetch at 0x04 -> data granted, stallFetch = 1; next cycle dataValid = 1, fetchValid = 0.
REQ-026 dataReq held high continuously with fetchReq = 1 and STARVE_MAX = 4 -> fetch stalled for 4 cycles and granted in the 5th, with stallMemory = 1 in that cycle; starveCount then returns to 0.
REQ-027 Data write with byteEnable = 4'b0011 and data 0xDEADBEEF at 0x08 -> ramWriteEnable = 1 and ramByteEnable = 0011 for one cycle; no dataValid pulse; a subsequent read of 0x08 returns 0x0000BEEF over a zeroed word.
REQ-028 Reset asserted in the cycle a fetch is granted -> no fetchValid after reset release; starveCount = 0; ramWriteEnable = 0 throughout reset.

Source files
------------

// File: rtl/jzjpcc_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the memory stage.
// Data has priority; a fetch starved for STARVE_MAX cycles takes one grant.
module jzjpcc_mem_arbiter #(
   parameter int RAM_A_WIDTH = 12,
   parameter int PC_MAX_B    = RAM_A_WIDTH + 1,
   parameter int STARVE_MAX  = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   fetchReq,
   input  logic [PC_MAX_B:2]      fetchAddr,
   output logic                   stallFetch,
   output logic                   fetchValid,
   output logic [31:0]            fetchData,
   input  logic                   dataReq,
   input  logic                   dataWrite,
   input  logic [3:0]             dataByteEnable,
   input  logic [PC_MAX_B:2]      dataAddr,
   input  logic [31:0]            dataWriteData,
   output logic                   stallMemory,
   output logic                   dataValid,
   output logic [31:0]            dataReadData,
   output logic [RAM_A_WIDTH-1:0] ramAddr,
   output logic                   ramWriteEnable,
   output logic [3:0]             ramByteEnable,
   output logic [31:0]            ramWriteData,
   input  logic [31:0]            ramReadData
);

   typedef enum logic [1:0] {
      OWN_NONE      = 2'd0,
      OWN_FETCH     = 2'd1,
      OWN_DATA_READ = 2'd2
   } owner_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   owner_e     owner_q, owner_d;
   logic [3:0] starve_q, starve_d;
   logic       starve_hit_s;
   logic       fetch_gnt_s;
   logic       data_gnt_s;

   // Grant decision, RAM port steering and next-state computation
   always_comb begin
      starve_hit_s   = (starve_q == STARVE_LIM);
      fetch_gnt_s    = fetchReq & (~dataReq | starve_hit_s);
      data_gnt_s     = dataReq & ~(fetchReq & starve_hit_s);
      stallFetch     = fetchReq & ~fetch_gnt_s;
      stallMemory    = dataReq & ~data_gnt_s;
      ramAddr        = {RAM_A_WIDTH{1'b0}};
      ramWriteEnable = 1'b0;
      ramByteEnable  = 4'b0000;
      ramWriteData   = 32'h0000_0000;
      owner_d        = OWN_NONE;
      starve_d       = 4'd0;

      if (fetch_gnt_s) begin
         ramAddr = fetchAddr[RAM_A_WIDTH+1:2];
         owner_d = OWN_FETCH;
      end else if (data_gnt_s) begin
         ramAddr        = dataAddr[RAM_A_WIDTH+1:2];
         ramWriteEnable = dataWrite & reset;
         ramByteEnable  = dataByteEnable;
         ramWriteData   = dataWriteData;
         owner_d        = dataWrite ? OWN_NONE : OWN_DATA_READ;
      end else begin
         owner_d = OWN_NONE;
      end

      // Saturating starvation counter, cleared whenever fetch is idle or served
      if (stallFetch) begin
         starve_d = starve_hit_s ? starve_q : starve_q + 4'd1;
      end else begin
         starve_d = 4'd0;
      end
   end

   // Owner and starvation state, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         owner_q  <= OWN_NONE;
         starve_q <= 4'd0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   // Return path: the RAM read data belongs to whoever owned last cycle's grant
   always_comb begin
      fetchValid   = (owner_q == OWN_FETCH);
      dataValid    = (owner_q == OWN_DATA_READ);
      fetchData    = fetchValid ? ramReadData : 32'h0000_0000;
      dataReadData = dataValid ? ramReadData : 32'h0000_0000;
   end

endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// Directed bench for jzjpcc_mem_arbiter with a behavioural byte-lane RAM.
module tb_jzjpcc_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetchReq;
   logic [13:2] fetchAddr;
   logic        stallFetch, fetchValid;
   logic [31:0] fetchData;
   logic        dataReq, dataWrite;
   logic [3:0]  dataByteEnable;
   logic [13:2] dataAddr;
   logic [31:0] dataWriteData;
   logic        stallMemory, dataValid;
   logic [31:0] dataReadData;
   logic [11:0] ramAddr;
   logic        ramWriteEnable;
   logic [3:0]  ramByteEnable;
   logic [31:0] ramWriteData;
   logic [31:0] ramReadData;

   logic [31:0] mem [0:4095];
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   jzjpcc_mem_arbiter dut (
      .clock(clock), .reset(reset),
      .fetchReq(fetchReq), .fetchAddr(fetchAddr), .stallFetch(stallFetch),
      .fetchValid(fetchValid), .fetchData(fetchData),
      .dataReq(dataReq), .dataWrite(dataWrite), .dataByteEnable(dataByteEnable),
      .dataAddr(dataAddr), .dataWriteData(dataWriteData), .stallMemory(stallMemory),
      .dataValid(dataValid), .dataReadData(dataReadData),
      .ramAddr(ramAddr), .ramWriteEnable(ramWriteEnable), .ramByteEnable(ramByteEnable),
      .ramWriteData(ramWriteData), .ramReadData(ramReadData)
   );

   // Synchronous RAM model, one-cycle registered read, byte-lane writes
   always @(posedge clock) begin
      if (ramWriteEnable) begin
         for (int b = 0; b < 4; b++) begin
            if (ramByteEnable[b]) mem[ramAddr][b*8 +: 8] <= ramWriteData[b*8 +: 8];
         end
      end
      ramReadData <= mem[ramAddr];
   end

   function automatic logic [31:0] pattern(input logic [11:0] a);
      return 32'hC0DE_0000 | {20'h0, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic [11:0] fa, input logic dr, input logic dw,
                        input logic [3:0] be, input logic [11:0] da, input logic [31:0] wd);
      fetchReq = fr; fetchAddr = fa; dataReq = dr; dataWrite = dw;
      dataByteEnable = be; dataAddr = da; dataWriteData = wd;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   typedef struct {
      logic        f_req;
      logic [11:0] f_addr;
      logic        d_req;
      logic        d_wr;
      logic [3:0]  d_be;
      logic [11:0] d_addr;
      logic [31:0] d_wdata;
      logic        e_stall_f;
      logic        e_stall_m;
      logic [11:0] e_ram_addr;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic        e_fvalid;
      logic        e_dvalid;
   } vec_t;

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{1'b1, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h010, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 12'h004, 1'b1, 1'b0, 4'h0, 12'h020, 32'h0, 1'b1, 1'b0, 12'h020, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 12'h000, 1'b1, 1'b0, 4'h0, 12'h021, 32'h0, 1'b0, 1'b0, 12'h021, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 12'h000, 1'b1, 1'b1, 4'hA, 12'h100, 32'h12345678, 1'b0, 1'b0, 12'h100, 1'b1, 4'hA, 32'h12345678, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 12'hFFF, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 12'hFFF, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 12'h006, 1'b1, 1'b1, 4'hF, 12'h101, 32'hCAFEF00D, 1'b1, 1'b0, 12'h101, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 12'h005, 1'b1, 1'b0, 4'h0, 12'h022, 32'h0, 1'b1, 1'b0, 12'h022, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 12'h005, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h005, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 12'h000, 1'b1, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 4'hF, 12'h7FF, 32'hFFFFFFFF, 1'b0, 1'b0, 12'h000, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};

      for (int i = 0; i < 4096; i++) mem[i] = pattern(12'(i));

      // Reset with a write request pending: no strobe, no valids
      reset = 1'b0;
      drive(1'b0, 12'h000, 1'b1, 1'b1, 4'hF, 12'h300, 32'h55555555);
      next_cycle();
      #2;
      chk("rst_we", {31'h0, ramWriteEnable}, 32'h0);
      next_cycle();
      chk("rst_fvalid", {31'h0, fetchValid}, 32'h0);
      chk("rst_dvalid", {31'h0, dataValid}, 32'h0);
      chk("rst_fdata", fetchData, 32'h0);
      chk("rst_ddata", dataReadData, 32'h0);
      reset = 1'b1;
      drive(1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
      next_cycle();

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_wr,
               vecs[i].d_be, vecs[i].d_addr, vecs[i].d_wdata);
         #2;
         chk($sformatf("v%0d_stallF", i), {31'h0, stallFetch}, {31'h0, vecs[i].e_stall_f});
         chk($sformatf("v%0d_stallM", i), {31'h0, stallMemory}, {31'h0, vecs[i].e_stall_m});
         chk($sformatf("v%0d_ramAddr", i), {20'h0, ramAddr}, {20'h0, vecs[i].e_ram_addr});
         chk($sformatf("v%0d_we", i), {31'h0, ramWriteEnable}, {31'h0, vecs[i].e_we});
         if (!(vecs[i].f_req && !vecs[i].e_stall_f)) begin
            chk($sformatf("v%0d_be", i), {28'h0, ramByteEnable}, {28'h0, vecs[i].e_be});
            chk($sformatf("v%0d_wdata", i), ramWriteData, vecs[i].e_wdata);
         end
         next_cycle();
         chk($sformatf("v%0d_fvalid", i), {31'h0, fetchValid}, {31'h0, vecs[i].e_fvalid});
         chk($sformatf("v%0d_dvalid", i), {31'h0, dataValid}, {31'h0, vecs[i].e_dvalid});
         chk($sformatf("v%0d_fdata", i), fetchData,
             vecs[i].e_fvalid ? pattern(vecs[i].f_addr) : 32'h0);
         chk($sformatf("v%0d_ddata", i), dataReadData,
             vecs[i].e_dvalid ? pattern(vecs[i].d_addr) : 32'h0);
      end

      // Starvation: four stalled cycles, fetch wins the fifth, counter restarts
      drive(1'b1, 12'h040, 1'b1, 1'b0, 4'h0, 12'h030, 32'h0);
      for (int c = 0; c < 5; c++) begin
         #2;
         chk($sformatf("starve%0d_stallF", c), {31'h0, stallFetch}, (c == 4) ? 32'h0 : 32'h1);
         chk($sformatf("starve%0d_stallM", c), {31'h0, stallMemory}, (c == 4) ? 32'h1 : 32'h0);
         next_cycle();
      end
      chk("starve_fvalid", {31'h0, fetchValid}, 32'h1);
      chk("starve_fdata", fetchData, pattern(12'h040));
      #2;
      chk("starve_cleared_stallF", {31'h0, stallFetch}, 32'h1);
      chk("starve_cleared_stallM", {31'h0, stallMemory}, 32'h0);
      drive(1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
      next_cycle();
      next_cycle();

      // Partial write over a zeroed word, then read it back
      drive(1'b0, 12'h000, 1'b1, 1'b1, 4'hF, 12'h008, 32'h0);
      next_cycle();
      drive(1'b0, 12'h000, 1'b1, 1'b1, 4'b0011, 12'h008, 32'hDEADBEEF);
      #2;
      chk("wr_we", {31'h0, ramWriteEnable}, 32'h1);
      chk("wr_be", {28'h0, ramByteEnable}, 32'h3);
      next_cycle();
      chk("wr_no_dvalid", {31'h0, dataValid}, 32'h0);
      drive(1'b0, 12'h000, 1'b1, 1'b0, 4'h0, 12'h008, 32'h0);
      #2;
      chk("rd_we", {31'h0, ramWriteEnable}, 32'h0);
      next_cycle();
      chk("rd_dvalid", {31'h0, dataValid}, 32'h1);
      chk("rd_data", dataReadData, 32'h0000BEEF);
      drive(1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
      next_cycle();

      // Reset lands on a fetch grant; the read must be dropped
      reset = 1'b0;
      drive(1'b1, 12'h010, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
      #2;
      chk("rstg_stallF", {31'h0, stallFetch}, 32'h0);
      next_cycle();
      drive(1'b0, 12'h000, 1'b1, 1'b1, 4'hF, 12'h200, 32'hFFFFFFFF);
      #2;
      chk("rstg_we", {31'h0, ramWriteEnable}, 32'h0);
      chk("rstg_fvalid", {31'h0, fetchValid}, 32'h0);
      next_cycle();
      reset = 1'b1;
      drive(1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
      #2;
      chk("rstg_rel_fvalid", {31'h0, fetchValid}, 32'h0);
      chk("rstg_rel_fdata", fetchData, 32'h0);
      next_cycle();
      chk("rstg_rel2_fvalid", {31'h0, fetchValid}, 32'h0);
      chk("rstg_mem_untouched", mem[12'h200], pattern(12'h200));
      drive(1'b1, 12'h044, 1'b1, 1'b0, 4'h0, 12'h034, 32'h0);
      for (int c = 0; c < 5; c++) begin
         #2;
         chk($sformatf("post_rst%0d_stallF", c), {31'h0, stallFetch}, (c == 4) ? 32'h0 : 32'h1);
         next_cycle();
      end
      drive(1'b0, 12'h000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
